// File: rtl/lsu_mem_initiator_pkg.sv
// lsu_mem_initiator_pkg: op and state encodings plus the misalignment rule shared by the LSU
package lsu_mem_initiator_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LH  = 3'd1,
        OP_LW  = 3'd2,
        OP_LBU = 3'd3,
        OP_LHU = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RSP  = 2'd3
    } state_e;

    // Unknown encodings fall through to the error path like a misaligned access
    function automatic logic misaligned(input op_e op, input logic [1:0] off);
        case (op)
            OP_LB, OP_LBU, OP_SB: misaligned = 1'b0;
            OP_LH, OP_LHU, OP_SH: misaligned = off[0];
            OP_LW, OP_SW:         misaligned = off != 2'd0;
            default:              misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic is_store(input op_e op);
        is_store = op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

endpackage

// File: rtl/lsu_mem_initiator_lane_align.sv
// lsu_lane_align: little-endian load extraction/extension and store lane merge
module lsu_lane_align
    import lsu_mem_initiator_pkg::*;
(
    input  op_e         op,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] bm;
    logic [31:0] hm;

    // Select the addressed lane, extend it for loads, and splice store data into the read word
    always_comb begin
        b          = word[{off, 3'b000} +: 8];
        h          = off[1] ? word[31:16] : word[15:0];
        bm         = 32'h0000_00FF << {off, 3'b000};
        hm         = off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        load_data  = op == OP_LB  ? {{24{b[7]}}, b}  :
                     op == OP_LBU ? {24'b0, b}       :
                     op == OP_LH  ? {{16{h[15]}}, h} :
                     op == OP_LHU ? {16'b0, h}       : word;
        store_word = op == OP_SB ? (word & ~bm) | ({4{wdata[7:0]}} & bm)  :
                     op == OP_SH ? (word & ~hm) | ({2{wdata[15:0]}} & hm) : wdata;
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: single-outstanding load/store unit driving a word-wide synchronous-write memory
module lsu_mem_initiator
    import lsu_mem_initiator_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata
);

    state_e            state;
    state_e            state_nx;
    op_e               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              accept;
    logic [31:0]       load_data;
    logic [31:0]       store_word;

    assign accept = req_valid && req_ready;

    lsu_lane_align u_align (
        .op         (op_q),
        .off        (addr_q[1:0]),
        .word       (rdata_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Request capture on accept and read-word capture in RD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_LB;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= op_e'(req_op);
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= misaligned(op_e'(req_op), req_addr[1:0]);
            end
            if (state == S_RD) rdata_q <= mem_rdata;
        end
    end

    // Next state: errors skip memory, SW writes directly, sub-word stores read-modify-write
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = misaligned(op_e'(req_op), req_addr[1:0]) ? S_RSP :
                                            op_e'(req_op) == OP_SW ? S_WR : S_RD;
            S_RD:    state_nx = is_store(op_q) ? S_WR : S_RSP;
            S_WR:    state_nx = S_RSP;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs decoded from state; memory bus is quiet outside RD/WR
    always_comb begin
        req_ready = state == S_IDLE;
        rsp_valid = state == S_RSP;
        rsp_err   = rsp_valid && err_q;
        rsp_rdata = (rsp_valid && !err_q && !is_store(op_q)) ? load_data : 32'd0;
        mem_we    = state == S_WR;
        mem_addr  = (state == S_RD || state == S_WR) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        mem_wdata = mem_we ? (op_q == OP_SW ? wdata_q : store_word) : 32'd0;
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb_lsu_mem_initiator: directed checks of load/store timing, lane handling, errors and reset
module tb_lsu_mem_initiator;
    import lsu_mem_initiator_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        init_mem;
    logic [31:0] mem [0:63];

    int total = 0;
    int bad = 0;

    lsu_mem_initiator #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
            mem[4]  <= 32'h8899_AABB;
            mem[8]  <= 32'h1122_3344;
            mem[12] <= 32'hCAFE_F00D;
        end else if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] w,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_n, input int exp_we);
        logic [31:0] rd;
        logic        er;
        int          n;
        int          we;
        bit          got;
        rd = 32'd0;
        er = 1'b0;
        n = 0;
        we = 0;
        got = 0;
        chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
        req_op = op;
        req_addr = a;
        req_wdata = w;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            n++;
            if (mem_we) we++;
            if (rsp_valid) begin
                rd = rsp_rdata;
                er = rsp_err;
                got = 1;
            end
        end
        chk({tag, ".cycles"}, n, exp_n);
        chk({tag, ".rdata"}, rd, exp_rd);
        chk({tag, ".err"}, {31'd0, er}, {31'd0, exp_err});
        chk({tag, ".we_pulses"}, we, exp_we);
        @(negedge clk);
        chk({tag, ".pulse_end"}, {30'd0, rsp_valid, req_ready}, 32'd1);
    endtask

    initial begin
        int acc;
        int rsps;
        int prev;
        rst_n = 1'b0;
        init_mem = 1'b1;
        req_valid = 1'b0;
        req_op = 3'd0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst.ready", {31'd0, req_ready}, 32'd1);
        chk("rst.rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
        chk("rst.rdata", rsp_rdata, 32'd0);
        chk("rst.mem", {mem_addr[30:0], mem_we}, 32'd0);
        chk("rst.rdata_q", dut.rdata_q, 32'd0);
        init_mem = 1'b0;
        rst_n = 1'b1;

        run("lb11",  OP_LB,  32'h11, 32'd0, 32'hFFFF_FFAA, 1'b0, 2, 0);
        run("lbu11", OP_LBU, 32'h11, 32'd0, 32'h0000_00AA, 1'b0, 2, 0);
        run("lb10",  OP_LB,  32'h10, 32'd0, 32'hFFFF_FFBB, 1'b0, 2, 0);
        run("lb13",  OP_LB,  32'h13, 32'd0, 32'hFFFF_FF88, 1'b0, 2, 0);
        run("lhu12", OP_LHU, 32'h12, 32'd0, 32'h0000_8899, 1'b0, 2, 0);
        run("lh12",  OP_LH,  32'h12, 32'd0, 32'hFFFF_8899, 1'b0, 2, 0);
        run("lh10",  OP_LH,  32'h10, 32'd0, 32'hFFFF_AABB, 1'b0, 2, 0);
        run("lhu10", OP_LHU, 32'h10, 32'd0, 32'h0000_AABB, 1'b0, 2, 0);
        run("lw10",  OP_LW,  32'h10, 32'd0, 32'h8899_AABB, 1'b0, 2, 0);

        run("sb23",  OP_SB,  32'h23, 32'h0000_00EE, 32'd0, 1'b0, 3, 1);
        chk("sb23.mem", mem[8], 32'hEE22_3344);
        run("lw20",  OP_LW,  32'h20, 32'd0, 32'hEE22_3344, 1'b0, 2, 0);
        run("sh20",  OP_SH,  32'h20, 32'hFFFF_1234, 32'd0, 1'b0, 3, 1);
        chk("sh20.mem", mem[8], 32'hEE22_1234);
        run("sw24",  OP_SW,  32'h24, 32'hDEAD_BEEF, 32'd0, 1'b0, 2, 1);
        chk("sw24.mem", mem[9], 32'hDEAD_BEEF);

        run("sw06",  OP_SW,  32'h06, 32'h1234_5678, 32'd0, 1'b1, 1, 0);
        chk("sw06.mem", mem[1], 32'd0);
        run("lh11",  OP_LH,  32'h11, 32'd0, 32'd0, 1'b1, 1, 0);
        run("sh31",  OP_SH,  32'h31, 32'h0000_5555, 32'd0, 1'b1, 1, 0);
        run("lw22",  OP_LW,  32'h22, 32'd0, 32'd0, 1'b1, 1, 0);

        req_op = OP_SH;
        req_addr = 32'h30;
        req_wdata = 32'h0000_7777;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("abort.in_rd", {31'd0, mem_we}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort.ready", {31'd0, req_ready}, 32'd1);
        chk("abort.quiet", {30'd0, rsp_valid, mem_we}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("abort.hold", {30'd0, rsp_valid, mem_we}, 32'd0);
        end
        rst_n = 1'b1;
        chk("abort.mem", mem[12], 32'hCAFE_F00D);
        run("lw30",  OP_LW,  32'h30, 32'd0, 32'hCAFE_F00D, 1'b0, 2, 0);

        acc = 0;
        rsps = 0;
        prev = -3;
        req_op = OP_LW;
        req_addr = 32'h10;
        req_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            if (req_ready) begin
                chk("b2b.spacing", i - prev, 32'd3);
                prev = i;
                acc++;
            end
            if (rsp_valid) begin
                rsps++;
                chk("b2b.rdata", rsp_rdata, 32'h8899_AABB);
            end
        end
        req_valid = 1'b0;
        chk("b2b.accepts", acc, 32'd3);
        chk("b2b.rsps", rsps, 32'd3);
        @(negedge clk);
        chk("b2b.idle", {30'd0, rsp_valid, req_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
